timer_unit: RTL and testbench

General-purpose timer peripheral for the RV32I microcontroller, placed directly downstream of the control unit. It consumes the control unit's `timer_en` level and the TIM_PSC/TIM_ARR write strobes, which are decoded from the timer-opcode `alu_cntrl` codes together with the ALU/register data. It provides a prescaled up-counter with auto-reload, preload (shadow) registers, a one-cycle update-event pulse and a sticky interrupt flag.

---
 rtl/timer_unit.sv | 95 +++++++++
 tb/tb_timer_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_unit.sv
// Prescaled up-counter with auto-reload, shadowed PSC/ARR, update-event pulse
// and sticky interrupt flag.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | paused; cnt/pc held, register writes go straight to active
// S_RUN  | counting; register writes land in preload until the next wrap
module timer_unit #(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             timer_en,
  input  logic             psc_we,
  input  logic             arr_we,
  input  logic [31:0]      wdata,
  input  logic             irq_clr,
  output logic [CNT_W-1:0] cnt_q,
  output logic [PSC_W-1:0] psc_q,
  output logic [CNT_W-1:0] arr_q,
  output logic             running,
  output logic             uev,
  output logic             irq
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q;
  logic [PSC_W-1:0] pc_q, pc_d;
  logic [PSC_W-1:0] psc_act_q, psc_act_d, psc_pre_d;
  logic [CNT_W-1:0] arr_act_q, arr_act_d, arr_pre_d;
  logic [CNT_W-1:0] cnt_d;
  logic             eval, tick, wrap;
  logic             uev_q, irq_q;

  assign running = (state_q == S_RUN);
  assign uev     = uev_q;
  assign irq     = irq_q;

  always_comb begin
    // The edge that drops timer_en evaluates no tick, so pausing never loses phase.
    eval = (state_q == S_RUN) && timer_en;
    tick = eval && (pc_q >= psc_act_q);
    wrap = tick && (cnt_q >= arr_act_q);

    pc_d = pc_q;
    if (eval) pc_d = tick ? '0 : pc_q + PSC_W'(1);

    cnt_d = cnt_q;
    if (tick) cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);

    psc_pre_d = psc_we ? wdata[PSC_W-1:0] : psc_q;
    arr_pre_d = arr_we ? wdata[CNT_W-1:0] : arr_q;

    // A write coinciding with a wrap reaches active through the preload mux.
    psc_act_d = psc_act_q;
    if (wrap) psc_act_d = psc_pre_d;
    else if ((state_q == S_IDLE) && psc_we) psc_act_d = wdata[PSC_W-1:0];

    arr_act_d = arr_act_q;
    if (wrap) arr_act_d = arr_pre_d;
    else if ((state_q == S_IDLE) && arr_we) arr_act_d = wdata[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      psc_q     <= '0;
      psc_act_q <= '0;
      arr_q     <= '1;
      arr_act_q <= '1;
      uev_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  if (timer_en)  state_q <= S_RUN;
        S_RUN:   if (!timer_en) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      psc_q     <= psc_pre_d;
      arr_q     <= arr_pre_d;
      psc_act_q <= psc_act_d;
      arr_act_q <= arr_act_d;
      uev_q     <= wrap;
      if (wrap)         irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_unit.sv
// Directed bench for timer_unit; expected values are hand-computed per edge.
module tb_timer_unit;

  logic        clk, reset, timer_en, psc_we, arr_we, irq_clr;
  logic [31:0] wdata;
  logic [31:0] cnt_q, arr_q;
  logic [15:0] psc_q;
  logic        running, uev, irq;

  int checks = 0;
  int errors = 0;

  timer_unit #(.CNT_W(32), .PSC_W(16)) dut (
    .clk(clk), .reset(reset), .timer_en(timer_en), .psc_we(psc_we),
    .arr_we(arr_we), .wdata(wdata), .irq_clr(irq_clr), .cnt_q(cnt_q),
    .psc_q(psc_q), .arr_q(arr_q), .running(running), .uev(uev), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wr_arr(input logic [31:0] v);
    arr_we = 1'b1; wdata = v;
    step();
    arr_we = 1'b0;
  endtask

  task automatic wr_psc(input logic [31:0] v);
    psc_we = 1'b1; wdata = v;
    step();
    psc_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; timer_en = 1'b0; psc_we = 1'b0; arr_we = 1'b0;
    wdata = '0; irq_clr = 1'b0;
    step(); step();
    reset = 1'b0;
    repeat (5) step();
    chk("rst_cnt", cnt_q, 0);
    chk("rst_psc", {16'b0, psc_q}, 0);
    chk("rst_arr", arr_q, 32'hFFFF_FFFF);
    chk1("rst_uev", uev, 1'b0);
    chk1("rst_irq", irq, 1'b0);
    chk1("rst_running", running, 1'b0);

    // ARR=3, PSC=0: 1,2,3,0 with uev every 4 cycles
    wr_arr(3);
    chk("idle_wr_arr", arr_q, 3);
    wr_psc(0);
    chk("idle_wr_psc", {16'b0, psc_q}, 0);
    timer_en = 1'b1;
    step();
    chk1("en_running", running, 1'b1);
    chk("en_cnt", cnt_q, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("a3_cnt", cnt_q, i);
      chk1("a3_uev_lo", uev, 1'b0);
    end
    step();
    chk("a3_wrap_cnt", cnt_q, 0);
    chk1("a3_wrap_uev", uev, 1'b1);
    chk1("a3_wrap_irq", irq, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("a3_cnt2", cnt_q, i);
      chk1("a3_uev_lo2", uev, 1'b0);
      chk1("a3_irq_held", irq, 1'b1);
    end
    step();
    chk("a3_wrap2_cnt", cnt_q, 0);
    chk1("a3_wrap2_uev", uev, 1'b1);
    timer_en = 1'b0;
    step();
    chk1("pause_running", running, 1'b0);
    chk("pause_cnt", cnt_q, 0);
    chk1("pause_uev", uev, 1'b0);

    // PSC=2, ARR=1 with a mid-count pause of 4 non-evaluating edges
    wr_psc(2);
    wr_arr(1);
    timer_en = 1'b1;
    step();
    chk1("p2_running", running, 1'b1);
    step(); step();
    chk("p2_cnt_k2", cnt_q, 0);
    step();
    chk("p2_cnt_k3", cnt_q, 1);
    chk1("p2_uev_k3", uev, 1'b0);
    step(); step();
    chk("p2_cnt_k5", cnt_q, 1);
    step();
    chk("p2_cnt_k6", cnt_q, 0);
    chk1("p2_uev_k6", uev, 1'b1);
    step();
    chk1("p2_uev_k7", uev, 1'b0);
    step();
    timer_en = 1'b0;
    step();
    chk1("p2_pause_running", running, 1'b0);
    chk("p2_pause_cnt", cnt_q, 0);
    step(); step();
    timer_en = 1'b1;
    step();
    chk1("p2_resume_running", running, 1'b1);
    chk("p2_resume_cnt", cnt_q, 0);
    step();
    chk("p2_cnt_k13", cnt_q, 1);
    step(); step();
    chk("p2_cnt_k15", cnt_q, 1);
    chk1("p2_uev_k15", uev, 1'b0);
    step();
    chk("p2_cnt_k16", cnt_q, 0);
    chk1("p2_uev_k16", uev, 1'b1);
    timer_en = 1'b0;
    step();

    // ARR=7 running, write ARR=2 at cnt=5: wrap still at 7, then period 3
    wr_psc(0);
    wr_arr(7);
    timer_en = 1'b1;
    step();
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("a7_cnt", cnt_q, i);
    end
    arr_we = 1'b1; wdata = 2;
    step();
    arr_we = 1'b0;
    chk("run_wr_arr_q", arr_q, 2);
    chk("run_wr_cnt6", cnt_q, 6);
    step();
    chk("run_wr_cnt7", cnt_q, 7);
    chk1("run_wr_uev7", uev, 1'b0);
    step();
    chk("run_wr_wrap_cnt", cnt_q, 0);
    chk1("run_wr_wrap_uev", uev, 1'b1);
    step(); step();
    chk("a2_cnt2", cnt_q, 2);
    step();
    chk("a2_wrap_cnt", cnt_q, 0);
    chk1("a2_wrap_uev", uev, 1'b1);
    step(); step();
    chk("a2_cnt2b", cnt_q, 2);
    // write coincident with wrap: ARR=7 takes effect immediately
    arr_we = 1'b1; wdata = 7;
    step();
    arr_we = 1'b0;
    chk("coinc_cnt", cnt_q, 0);
    chk1("coinc_uev", uev, 1'b1);
    chk("coinc_arr_q", arr_q, 7);
    step(); step(); step();
    chk("coinc_cnt3", cnt_q, 3);
    chk1("coinc_uev3", uev, 1'b0);
    step(); step(); step();
    chk("coinc_cnt6", cnt_q, 6);

    // pause at 6, lower ARR to 3 in IDLE: next tick wraps
    timer_en = 1'b0;
    step();
    chk1("low_pause_running", running, 1'b0);
    chk("low_pause_cnt", cnt_q, 6);
    wr_arr(3);
    chk("low_arr_q", arr_q, 3);
    chk("low_cnt_held", cnt_q, 6);
    timer_en = 1'b1;
    step();
    chk1("low_running", running, 1'b1);
    chk("low_cnt_en", cnt_q, 6);
    chk1("low_uev_en", uev, 1'b0);
    step();
    chk("low_wrap_cnt", cnt_q, 0);
    chk1("low_wrap_uev", uev, 1'b1);

    // irq_clr coincident with wrap, then alone
    step(); step(); step();
    chk("clr_cnt3", cnt_q, 3);
    irq_clr = 1'b1;
    step();
    chk1("clr_wrap_uev", uev, 1'b1);
    chk1("clr_wrap_irq", irq, 1'b1);
    step();
    chk1("clr_irq", irq, 1'b0);
    chk("clr_cnt1", cnt_q, 1);
    irq_clr = 1'b0;
    step();
    chk1("clr_irq_stays", irq, 1'b0);
    chk("clr_cnt2", cnt_q, 2);

    // PSC=5 mid-count, then reset with conflicting inputs
    timer_en = 1'b0;
    step();
    chk("p5_pause_cnt", cnt_q, 2);
    wr_psc(5);
    chk("p5_psc_q", {16'b0, psc_q}, 5);
    timer_en = 1'b1;
    step();
    repeat (6) step();
    chk("p5_cnt_e6", cnt_q, 3);
    repeat (6) step();
    chk("p5_cnt_e12", cnt_q, 0);
    chk1("p5_uev_e12", uev, 1'b1);
    chk1("p5_irq_e12", irq, 1'b1);
    repeat (6) step();
    chk("p5_cnt_e18", cnt_q, 1);
    chk1("p5_irq_e18", irq, 1'b1);
    chk1("p5_uev_e18", uev, 1'b0);
    reset = 1'b1; psc_we = 1'b1; arr_we = 1'b1; wdata = 9;
    step();
    chk("mid_rst_cnt", cnt_q, 0);
    chk("mid_rst_psc", {16'b0, psc_q}, 0);
    chk("mid_rst_arr", arr_q, 32'hFFFF_FFFF);
    chk1("mid_rst_running", running, 1'b0);
    chk1("mid_rst_uev", uev, 1'b0);
    chk1("mid_rst_irq", irq, 1'b0);
    reset = 1'b0; psc_we = 1'b0; arr_we = 1'b0; timer_en = 1'b0;
    step();
    chk("post_rst_cnt", cnt_q, 0);
    chk1("post_rst_running", running, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
